sub_seq_sliced_ctrl: RTL and testbench
======================================

Name: sub_seq_sliced_ctrl

Overview:
- Multi-cycle sequencer that computes an unsigned WIDTH-bit subtraction A - B by time-sharing one SLICE-bit subtractor slice, LSB slice first, with the borrow carried between cycles in a register.
- Used where area matters more than latency.
- Same result/borrow contract as the combinational subtractors in the subtractor library, wrapped in valid/ready handshakes on input and output.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SLICE, 8, width of the shared subtractor slice. WIDTH % SLICE must be 0; otherwise elaboration fails via a generate-time error.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands A/B valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  unsigned minuend.
- B  input  WIDTH  unsigned subtrahend.
- out_valid  output  1  result/borrow valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  A - B modulo 2^WIDTH.
- borrow  output  1  1 iff A < B.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Derived constant: NSLICES = WIDTH/SLICE.
- FSM states: IDLE, RUN, DONE.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, borrow=0, slice index=0, borrow register=0.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready: latch A and B into operand registers, clear the borrow register, set index=0, go to RUN.
- RUN:
  - in_ready=0; A, B and in_valid are ignored.
  - Each cycle, the slice subtracts bits [idx*SLICE +: SLICE] of the latched operands with borrow-in = borrow register.
  - Slice difference is written into the matching result bits; borrow-out is stored into the borrow register; index increments.
  - After the slice with idx=NSLICES-1, go to DONE.
- DONE:
  - out_valid=1; result and borrow are held stable until the handshake.
  - borrow = final slice borrow-out, which must equal (A<B).
  - On an edge with out_valid&&out_ready: go to IDLE. in_ready=1 from the next cycle.
  - No same-cycle accept of new operands in DONE.
- Latency: out_valid rises exactly NSLICES cycles after the accepting edge (SLICE=WIDTH gives 1 cycle).
- Throughput: at most one operation per NSLICES+1 cycles with out_ready held high.
- Result bits not yet computed in RUN are don't-care. Consumers only sample on out_valid.
- Output backpressure: out_ready low holds DONE indefinitely with outputs frozen.
- Reset mid-RUN or mid-DONE: the operation is abandoned and all outputs return to reset values on the next edge. No partial result is ever flagged valid.
- Arithmetic:
  - Slice computes {bout, d} = {1'b0, a_s} - {1'b0, b_s} - bin, with SLICE+1-bit width.
  - All values are unsigned; there is no sign extension.

Decomposition:
- Shared package sub_pkg:
  - State enum sub_seq_state_e {IDLE, RUN, DONE}.
  - Function nslices(width, slice).
  - Localparam default WIDTH/SLICE.
- One natural sub-module: sub_slice_unsigned (SLICE-bit A - B with borrow-in and borrow-out, purely combinational).
- The controller holds the FSM, index counter, operand/result registers and borrow register.

Test Plan:
- A=5, B=3, out_ready=1 -> out_valid 4 cycles after accept, result=0x00000002, borrow=0.
- A=0, B=1 -> result=0xFFFFFFFF, borrow=1 (borrow ripples through all 4 slices).
- A=0x00000100, B=0x00000001 -> result=0x000000FF, borrow=0 (inter-slice borrow). A=B=0xDEADBEEF -> result=0, borrow=0.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, result and borrow stable, in_ready=0. After out_ready=1, in_ready=1 next cycle. A/B toggled during RUN do not change the result.
- rst pulsed on 2nd RUN cycle -> next cycle out_valid=0, in_ready=1, result=0, borrow=0. A fresh op 7-9 then yields 0xFFFFFFFE, borrow=1.
- Back-to-back random ops with SLICE in {1,8,16,32}, compared against the reference model (A-B, A<B) -> all match, with latency = WIDTH/SLICE.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared types and helpers for the sliced sequential subtractor.
package sub_pkg;

    // Controller states: wait for operands, iterate over slices, hold result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_seq_state_e;

    localparam int SUB_WIDTH_DEF = 32;
    localparam int SUB_SLICE_DEF = 8;

    // Number of slice iterations needed to cover the full operand width.
    function automatic int nslices(input int width, input int slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/sub_slice_unsigned.sv
// One SLICE-bit unsigned subtractor slice with borrow in and borrow out.
module sub_slice_unsigned #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             bin_i,
    output logic [SLICE-1:0] d_o,
    output logic             bout_o
);

    logic [SLICE:0] full_s;

    // Extend by one bit so the top bit of the difference is the borrow-out.
    always_comb begin
        full_s = {1'b0, a_i} - {1'b0, b_i} - {{SLICE{1'b0}}, bin_i};
        d_o    = full_s[SLICE-1:0];
        bout_o = full_s[SLICE];
    end

endmodule

// File: rtl/sub_seq_sliced_ctrl.sv
// Multi-cycle WIDTH-bit unsigned subtractor that reuses one SLICE-bit slice,
// LSB slice first, carrying the borrow between cycles in a register.
module sub_seq_sliced_ctrl
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF,
    parameter int SLICE = SUB_SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             borrow,
    output logic             busy
);

    localparam int NSLICES = nslices(WIDTH, SLICE);
    localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("sub_seq_sliced_ctrl: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    sub_seq_state_e   state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic [IDX_W-1:0] idx_q;
    logic             bin_q;
    logic             borrow_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [SLICE-1:0] slice_a_s;
    logic [SLICE-1:0] slice_b_s;
    logic [SLICE-1:0] slice_d_s;
    logic             slice_bout_s;

    // Select the operand bits for the slice currently being processed.
    always_comb begin
        slice_a_s = a_q[int'(idx_q) * SLICE +: SLICE];
        slice_b_s = b_q[int'(idx_q) * SLICE +: SLICE];
    end

    sub_slice_unsigned #(
        .SLICE (SLICE)
    ) u_slice (
        .a_i    (slice_a_s),
        .b_i    (slice_b_s),
        .bin_i  (bin_q),
        .d_o    (slice_d_s),
        .bout_o (slice_bout_s)
    );

    // Controller FSM: operand capture, slice iteration and result handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            result_q    <= {WIDTH{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            bin_q       <= 1'b0;
            borrow_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= A;
                        b_q        <= B;
                        bin_q      <= 1'b0;
                        idx_q      <= {IDX_W{1'b0}};
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    result_q[int'(idx_q) * SLICE +: SLICE] <= slice_d_s;
                    bin_q <= slice_bout_s;
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        borrow_q    <= slice_bout_s;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // New operands are only taken once back in IDLE.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign borrow    = borrow_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sub_seq_sliced_ctrl.sv
// Directed bench for the sliced subtractor; four instances with SLICE 1/8/16/32
// share the same operands and are checked for result, borrow and latency.
module tb_sub_seq_sliced_ctrl;

    localparam int NK = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 out_ready;
    logic [31:0]          a_s;
    logic [31:0]          b_s;
    logic [NK-1:0]        in_ready_s;
    logic [NK-1:0]        out_valid_s;
    logic [NK-1:0]        borrow_s;
    logic [NK-1:0]        busy_s;
    logic [NK-1:0][31:0]  result_s;

    int n_checks = 0;
    int n_errors = 0;

    function automatic int slice_of(input int k);
        case (k)
            0:       return 1;
            1:       return 8;
            2:       return 16;
            default: return 32;
        endcase
    endfunction

    generate
        for (genvar k = 0; k < NK; k++) begin : g_dut
            localparam int SL = (k == 0) ? 1 : (k == 1) ? 8 : (k == 2) ? 16 : 32;
            sub_seq_sliced_ctrl #(
                .WIDTH (32),
                .SLICE (SL)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .in_ready  (in_ready_s[k]),
                .A         (a_s),
                .B         (b_s),
                .out_valid (out_valid_s[k]),
                .out_ready (out_ready),
                .result    (result_s[k]),
                .borrow    (borrow_s[k]),
                .busy      (busy_s[k])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_reset(input string tag);
        check_eq({tag, "_in_ready"},  {28'd0, in_ready_s},  32'h0000_000F);
        check_eq({tag, "_out_valid"}, {28'd0, out_valid_s}, 32'h0000_0000);
        check_eq({tag, "_busy"},      {28'd0, busy_s},      32'h0000_0000);
        check_eq({tag, "_borrow"},    {28'd0, borrow_s},    32'h0000_0000);
        for (int k = 0; k < NK; k++) begin
            check_eq($sformatf("%s_result_k%0d", tag, k), result_s[k], 32'h0000_0000);
        end
    endtask

    // One operation on all instances; bp holds out_ready low in DONE for 5 cycles.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] er, input logic eb,
                          input bit bp, input string tag);
        out_ready = !bp;
        a_s       = av;
        b_s       = bv;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        a_s       = ~av;
        b_s       = av ^ 32'h5A5A_A5A5;
        check_eq({tag, "_acc_in_ready"}, {28'd0, in_ready_s},  32'h0000_0000);
        check_eq({tag, "_acc_busy"},     {28'd0, busy_s},      32'h0000_000F);
        check_eq({tag, "_acc_valid"},    {28'd0, out_valid_s}, 32'h0000_0000);
        for (int c = 1; c <= 32; c++) begin
            tick();
            if ((c % 3) == 0) begin
                a_s = $urandom;
                b_s = $urandom;
            end
            for (int k = 0; k < NK; k++) begin
                int ns;
                ns = 32 / slice_of(k);
                if (c == ns) begin
                    check_eq($sformatf("%s_valid_k%0d_c%0d", tag, k, c), {31'd0, out_valid_s[k]}, 32'd1);
                    check_eq($sformatf("%s_result_k%0d", tag, k), result_s[k], er);
                    check_eq($sformatf("%s_borrow_k%0d", tag, k), {31'd0, borrow_s[k]}, {31'd0, eb});
                end else if (c == ns - 1) begin
                    check_eq($sformatf("%s_early_k%0d_c%0d", tag, k, c), {31'd0, out_valid_s[k]}, 32'd0);
                end
            end
        end
        if (bp) begin
            for (int h = 0; h < 5; h++) begin
                tick();
                check_eq($sformatf("%s_hold_valid_%0d", tag, h), {28'd0, out_valid_s}, 32'h0000_000F);
                check_eq($sformatf("%s_hold_in_ready_%0d", tag, h), {28'd0, in_ready_s}, 32'h0000_0000);
                for (int k = 0; k < NK; k++) begin
                    check_eq($sformatf("%s_hold_res_k%0d_%0d", tag, k, h), result_s[k], er);
                    check_eq($sformatf("%s_hold_brw_k%0d_%0d", tag, k, h), {31'd0, borrow_s[k]}, {31'd0, eb});
                end
            end
        end
        out_ready = 1'b1;
        tick();
        check_eq({tag, "_end_in_ready"}, {28'd0, in_ready_s},  32'h0000_000F);
        check_eq({tag, "_end_valid"},    {28'd0, out_valid_s}, 32'h0000_0000);
        check_eq({tag, "_end_busy"},     {28'd0, busy_s},      32'h0000_0000);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_s       = 32'h0000_0000;
        b_s       = 32'h0000_0000;
        tick();
        tick();
        check_all_reset("reset");
        rst = 1'b0;
        tick();

        run_op(32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, "5m3");
        run_op(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, "0m1");
        run_op(32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, "x100m1");
        run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0, "equal");
        run_op(32'h1234_5678, 32'h0000_0009, 32'h1234_566F, 1'b0, 1'b1, "bpress");

        // Reset sampled at the end of the second RUN cycle abandons the op.
        a_s      = 32'h0000_0005;
        b_s      = 32'h0000_0003;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_reset("midrun_rst");

        run_op(32'h0000_0007, 32'h0000_0009, 32'hFFFF_FFFE, 1'b1, 1'b0, "7m9");
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "maxm0");
        run_op(32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, "0mmax");
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "msb");

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb, ra - rb, (ra < rb), 1'b0, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
